mips_mc_datapath: RTL and testbench



---
 rtl/mips_mc_datapath.sv | 152 +++++++++++++++
 tb/tb_mips_mc_datapath.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_datapath.sv
// mips_mc_datapath -- multicycle MIPS datapath.
//
// Holds the architectural state (PC and a 32x32 register file) and the
// inter-cycle registers (IR, MDR, A, B, ALUOut). The control FSM and the ALU
// decoder drive the per-cycle strobes. The datapath returns op, funct and zero
// to them. One unified memory port serves both fetches and loads/stores.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   pcwrite, branch   PC load enables (pcen = pcwrite | (branch & zero))
//   irwrite           load IR from readdata
//   regwrite          register file write enable
//   alusrca           ALU A: 0=PC, 1=A
//   iord              memory address: 0=PC, 1=ALUOut
//   memtoreg          regfile write data: 0=ALUOut, 1=MDR
//   regdst            regfile write addr: 0=IR[20:16], 1=IR[15:11]
//   alusrcb[1:0]      ALU B: B, 4, signimm, signimm<<2
//   pcsrc[1:0]        next PC: ALU result, ALUOut, jump target, ALU result
//   alucontrol[2:0]   AND/OR/ADD/SUB/SLT; unused codes give 0
//   readdata[31:0]    memory read data
//   op, funct         IR[31:26], IR[5:0]
//   zero              combinational ALU result == 0
//   adr[31:0]         memory address
//   writedata[31:0]   B register (store data)
//   instr_count[31:0] only with INSTR_COUNT_EN defined. Counts irwrite cycles
//                     and wraps at 2^32.
//
// Optional build macro: INSTR_COUNT_EN
module mips_mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcwrite,
  input  logic        branch,
  input  logic        irwrite,
  input  logic        regwrite,
  input  logic        alusrca,
  input  logic        iord,
  input  logic        memtoreg,
  input  logic        regdst,
  input  logic [1:0]  alusrcb,
  input  logic [1:0]  pcsrc,
  input  logic [2:0]  alucontrol,
  input  logic [31:0] readdata,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        zero,
  output logic [31:0] adr,
  output logic [31:0] writedata
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  logic [31:0] pc, ir, mdr, a_q, b_q, aluout;
  logic [31:0] rf [32];

  logic [4:0]  rs, rt, wa;
  logic [31:0] rd1, rd2, wd, signimm, srca, srcb, alures, pcnext;
  logic        pcen;

  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign signimm = {{16{ir[15]}}, ir[15:0]};
  assign op      = ir[31:26];
  assign funct   = ir[5:0];

  // Register file reads are combinational and unbypassed. A write and a read
  // of the same register in one cycle give A/B the pre-write value.
  assign rd1 = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rd2 = (rt == 5'd0) ? 32'd0 : rf[rt];
  assign wa  = regdst   ? ir[15:11] : rt;
  assign wd  = memtoreg ? mdr       : aluout;

  assign srca = alusrca ? a_q : pc;

  always_comb begin
    srcb = b_q;
    case (alusrcb)
      2'b00: srcb = b_q;
      2'b01: srcb = 32'd4;
      2'b10: srcb = signimm;
      2'b11: srcb = {signimm[29:0], 2'b00};
    endcase
  end

  always_comb begin
    alures = 32'd0;
    case (alucontrol)
      3'b000:  alures = srca & srcb;
      3'b001:  alures = srca | srcb;
      3'b010:  alures = srca + srcb;
      3'b110:  alures = srca - srcb;
      3'b111:  alures = {31'd0, $signed(srca) < $signed(srcb)};
      default: alures = 32'd0;
    endcase
  end

  assign zero = (alures == 32'd0);

  // The jump target takes its upper nibble from the PC of the current cycle.
  always_comb begin
    pcnext = alures;
    case (pcsrc)
      2'b00:   pcnext = alures;
      2'b01:   pcnext = aluout;
      2'b10:   pcnext = {pc[31:28], ir[25:0], 2'b00};
      default: pcnext = alures;
    endcase
  end

  assign pcen      = pcwrite | (branch & zero);
  assign adr       = iord ? aluout : pc;
  assign writedata = b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      aluout <= '0;
    end else begin
      if (pcen)    pc <= pcnext;
      if (irwrite) ir <= readdata;
      mdr    <= readdata;
      a_q    <= rd1;
      b_q    <= rd2;
      aluout <= alures;
    end
  end

  // r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (regwrite && (wa != 5'd0)) begin
      rf[wa] <= wd;
    end
  end

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        instr_count <= '0;
    else if (irwrite) instr_count <= instr_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mips_mc_datapath.sv
// Directed bench for mips_mc_datapath. Stimulus walks through a series of
// hand-decoded instruction sequences. At each observation point it pushes the
// expected value onto a scoreboard queue. A monitor drains and compares the
// queue on every falling edge.
module tb_mips_mc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcwrite, branch, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] adr, writedata;
`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                         A_SUB = 3'b110, A_SLT = 3'b111;
  localparam int K_ADR = 0, K_OP = 1, K_FUNCT = 2, K_ZERO = 3, K_WD = 4, K_CNT = 5;

  mips_mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .branch(branch),
    .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .readdata(readdata), .op(op), .funct(funct),
    .zero(zero), .adr(adr), .writedata(writedata)
`ifdef INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_ADR:   return adr;
      K_OP:    return {26'd0, op};
      K_FUNCT: return {26'd0, funct};
      K_ZERO:  return {31'd0, zero};
      K_WD:    return writedata;
`ifdef INSTR_COUNT_EN
      K_CNT:   return instr_count;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compares every queued expectation against the outputs it reads
  // away from the rising edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [31:0] got;
      c   = sb.pop_front();
      got = actual(c.kind);
      checks++;
      if (got !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", c.name, got, c.exp, $time);
      end
    end
  end

  task automatic expect_(input int k, input logic [31:0] v, input string n);
    chk_t c;
    c.kind = k; c.exp = v; c.name = n;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    pcwrite = 0; branch = 0; irwrite = 0; regwrite = 0; alusrca = 0; iord = 0;
    memtoreg = 0; regdst = 0; alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = A_AND;
  endtask

  // Fetch (IR <= instr, PC += 4), followed by a decode cycle. After decode,
  // A/B hold rf[rs]/rf[rt] and ALUOut holds PC + (signimm << 2).
  task automatic fetch(input logic [31:0] instr);
    idle();
    readdata = instr; irwrite = 1; alusrcb = 2'b01; alucontrol = A_ADD; pcwrite = 1;
    tick();
    exp_pc = exp_pc + 32'd4;
    idle();
    alusrcb = 2'b11; alucontrol = A_ADD;
    expect_(K_ADR, exp_pc, "fetch_adr");
    expect_(K_OP, {26'd0, instr[31:26]}, "fetch_op");
    expect_(K_FUNCT, {26'd0, instr[5:0]}, "fetch_funct");
    tick();
  endtask

  task automatic exec_i();
    idle(); alusrca = 1; alusrcb = 2'b10; alucontrol = A_ADD;
    tick();
  endtask

  task automatic exec_r(input logic [2:0] alu);
    idle(); alusrca = 1; alusrcb = 2'b00; alucontrol = alu;
    tick();
  endtask

  task automatic wb(input logic dst, input logic mtr);
    idle(); regwrite = 1; regdst = dst; memtoreg = mtr;
    tick();
    idle();
  endtask

  // Makes rf[rt] visible on writedata by fetching "sw rt,0($0)".
  task automatic show(input logic [4:0] rt, input logic [31:0] v, input string n);
    fetch(32'hAC00_0000 | ({27'd0, rt} << 16));
    expect_(K_WD, v, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; readdata = 32'd0; idle();
    exp_pc = 32'd0;
    tick(); tick();
    expect_(K_ADR, 32'd0, "rst_adr");
    expect_(K_OP, 32'd0, "rst_op");
    expect_(K_FUNCT, 32'd0, "rst_funct");
    expect_(K_WD, 32'd0, "rst_wd");
`ifdef INSTR_COUNT_EN
    expect_(K_CNT, 32'd0, "rst_cnt");
`endif
    tick();
    reset = 0;
    tick(); tick();
    expect_(K_ADR, 32'd0, "pc_hold_idle");
    tick();

    // addi $8,$0,5 followed by the no-bypass check on the writeback edge
    fetch(32'h2008_0005);
    idle(); alusrca = 1; alusrcb = 2'b10; alucontrol = A_ADD;
    expect_(K_ZERO, 32'd0, "addi_zero");
    tick();
    idle(); regwrite = 1; iord = 1;
    expect_(K_ADR, 32'd5, "aluout_adr");
    tick();
    idle();
    expect_(K_WD, 32'd0, "no_bypass");
    tick();
    show(5'd8, 32'd5, "sw_r8");

    // addi $9,$0,5; beq $8,$9,+3 taken from PC 16 -> 16+12 = 28
    fetch(32'h2009_0005); exec_i(); wb(0, 0);
    fetch(32'h1109_0003);
    idle(); alusrca = 1; alucontrol = A_SUB; pcsrc = 2'b01; branch = 1;
    expect_(K_ZERO, 32'd1, "beq_zero_taken");
    tick();
    exp_pc = 32'd28; idle();
    expect_(K_ADR, exp_pc, "beq_taken_pc");
    tick();

    // rf[9]=6, so the beq is not taken and the PC holds at 36
    fetch(32'h2009_0006); exec_i(); wb(0, 0);
    fetch(32'h1109_0003);
    idle(); alusrca = 1; alucontrol = A_SUB; pcsrc = 2'b01; branch = 1;
    expect_(K_ZERO, 32'd0, "beq_zero_nt");
    tick();
    idle();
    expect_(K_ADR, exp_pc, "beq_nt_pc");
    // pcwrite and branch together load even when zero=0. ALUOut = 5-6 wraps.
    alusrca = 1; alucontrol = A_SUB; pcsrc = 2'b01; branch = 1; pcwrite = 1;
    tick();
    exp_pc = 32'hFFFF_FFFF; idle();
    expect_(K_ADR, exp_pc, "pcw_and_branch");
    tick();

    // slt $11,$8,$9 (5<6); the fetch wraps the PC to 3
    fetch(32'h0109_582A); exec_r(A_SLT); wb(1, 0);
    show(5'd11, 32'd1, "slt_pos");
    // addi $12,$0,-1 sign-extends the immediate; slt $13,$12,$8 is a signed compare
    fetch(32'h200C_FFFF); exec_i(); wb(0, 0);
    show(5'd12, 32'hFFFF_FFFF, "addi_neg");
    fetch(32'h0188_682A); exec_r(A_SLT); wb(1, 0);
    show(5'd13, 32'd1, "slt_signed");
    // and $14,$12,$8; an unused alucontrol code gives 0
    fetch(32'h0188_7024);
    idle(); alusrca = 1; alucontrol = 3'b011;
    expect_(K_ZERO, 32'd1, "alu_unused_code");
    tick();
    idle(); alusrca = 1; alucontrol = A_AND;
    expect_(K_ZERO, 32'd0, "and_zero");
    tick();
    wb(1, 0);
    show(5'd14, 32'd5, "and_r14");

    // addi $0,$0,7 writes to r0, which must be ignored
    fetch(32'h2000_0007); exec_i(); wb(0, 0);
    show(5'd0, 32'd0, "r0_zero");

    // lw $10: MDR -> rf[10]=0x10000000, then the PC is set to it via or $0,$10,$10
    fetch(32'h8C0A_0000);
    idle(); readdata = 32'h1000_0000;
    tick();
    wb(0, 1);
    show(5'd10, 32'h1000_0000, "lw_r10");
    fetch(32'h014A_0025);
    idle(); alusrca = 1; alucontrol = A_OR; pcwrite = 1;
    tick();
    exp_pc = 32'h1000_0000; idle();
    expect_(K_ADR, exp_pc, "pc_set");
    tick();

    // j 0x10 from PC 0x10000004 -> 0x10000040
    fetch(32'h0800_0010);
    idle(); pcsrc = 2'b10; pcwrite = 1;
    tick();
    exp_pc = 32'h1000_0040; idle();
    expect_(K_ADR, exp_pc, "jump_pc");
    tick();

    // Reset asserted in the middle of an execute cycle clears state without waiting for an edge
    fetch(32'h2008_0009);
    idle(); alusrca = 1; alusrcb = 2'b10; alucontrol = A_ADD;
    #1 reset = 1;
    expect_(K_ADR, 32'd0, "midrst_adr");
    expect_(K_OP, 32'd0, "midrst_op");
    expect_(K_WD, 32'd0, "midrst_wd");
    tick(); tick();
    reset = 0; idle(); exp_pc = 32'd0;
    expect_(K_ADR, 32'd0, "refetch_adr");
    tick();
    show(5'd8, 32'd0, "rf_cleared");
    fetch(32'h0000_0000);
    fetch(32'h0000_0000);
`ifdef INSTR_COUNT_EN
    expect_(K_CNT, 32'd3, "instr_count");
`endif
    tick(); tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
